// File: rtl/dsp_mul_rr_arbiter.sv
// Round-robin share of one pipelined fix14 multiplier.
// Tags ride alongside the multiplier so results find their owner.
module dsp_mul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int D_W     = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   arb_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*D_W-1:0] req_a,
  input  logic [NUM_REQ*D_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [D_W-1:0]         rsp_data,
  output logic                   mul_ce,
  output logic [D_W-1:0]         mul_a,
  output logic [D_W-1:0]         mul_b,
  input  logic [D_W-1:0]         mul_res,
  output logic                   idle,
  output logic [1:0]             state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // issue stage + MUL_LAT multiplier stages + result capture
  localparam int TD = MUL_LAT + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } st_e;

  st_e              st_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic             hit;
  logic [IW:0]      sum;
  logic             allow;
  logic             xfer;
  logic             pipe_empty;
  logic [TD-1:0]    tag_v;
  logic [IW-1:0]    tag_id [TD];
  logic [D_W-1:0]   res_q;
  logic [NUM_REQ-1:0] rsp_oh;

  assign allow      = arb_en & (st_q != S_DRAIN);
  assign xfer       = |gnt;
  assign pipe_empty = ~|tag_v;
  assign req_ready  = gnt;
  assign idle       = (st_q == S_IDLE) & pipe_empty & ~xfer;
  assign state      = st_q;

  // rotating priority search starting at the pointer
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      if (!hit && req_valid[sum[IW-1:0]]) begin
        hit    = 1'b1;
        gnt_id = sum[IW-1:0];
      end
    end
    if (allow && hit)
      gnt[gnt_id] = 1'b1;
  end

  // pointer moves just past the requester that won
  always_comb begin
    ptr_nxt = gnt_id + IW'(1);
    if (gnt_id == IW'(NUM_REQ-1))
      ptr_nxt = '0;
  end

  // one-hot owner of the result leaving the tag pipe
  always_comb begin
    rsp_oh = '0;
    if (tag_v[TD-1])
      rsp_oh[tag_id[TD-1]] = 1'b1;
  end

  // issue, tag pipeline and response register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ptr_q     <= '0;
      mul_ce    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      res_q     <= '0;
      tag_v     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int i = 0; i < TD; i++)
        tag_id[i] <= '0;
    end else begin
      mul_ce <= 1'b1;
      res_q  <= mul_res;
      if (xfer) begin
        ptr_q <= ptr_nxt;
        mul_a <= req_a[gnt_id*D_W +: D_W];
        mul_b <= req_b[gnt_id*D_W +: D_W];
      end
      tag_v[0]  <= xfer;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < TD; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      rsp_valid <= rsp_oh;
      if (tag_v[TD-1])
        rsp_data <= res_q;
    end
  end

  // control state: run while granting, drain after disable
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      st_q <= S_IDLE;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (arb_en && |req_valid)
            st_q <= S_RUN;
        end
        S_RUN: begin
          if (!arb_en)
            st_q <= S_DRAIN;
          else if (!(|req_valid) && pipe_empty)
            st_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (pipe_empty)
            st_q <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mul_rr_arbiter.sv
// Directed bench for dsp_mul_rr_arbiter.
// Bench-side multiplier: 2-stage fix14 signed product.
module tb_dsp_mul_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        mul_ce;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_res;
  logic        idle;
  logic [1:0]  state;

  logic [15:0] s0;
  logic [15:0] s1;
  logic signed [31:0] prod;

  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] seen;

  always #5 clk = ~clk;

  dsp_mul_rr_arbiter dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mul_ce    (mul_ce),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_res   (mul_res),
    .idle      (idle),
    .state     (state)
  );

  assign prod    = $signed(mul_a) * $signed(mul_b);
  assign mul_res = s1;

  always_ff @(posedge clk) begin
    if (mul_ce) begin
      s0 <= prod[29:14];
      s1 <= s0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i,
                        input logic [15:0] a,
                        input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!idle && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(idle), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (4) step();
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    chk("rst_ce", 32'(mul_ce), 32'd0);
    chk("rst_rsp_v", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_d", 32'(rsp_data), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    step();
    chk("ce_on", 32'(mul_ce), 32'd1);

    // single op: 0x4000 * 0x4000 -> 0x4000, rsp 4 edges later
    set_op(0, 16'h4000, 16'h4000);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_idle_gnt", 32'(idle), 32'd0);
    step();
    req_valid = '0;
    chk("t1_mul_a", 32'(mul_a), 32'h4000);
    chk("t1_state", 32'(state), 32'd1);
    seen = '0;
    repeat (3) begin
      step();
      seen = seen | rsp_valid;
    end
    chk("t1_early", 32'(seen), 32'h0);
    step();
    chk("t1_rsp_v", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_d", 32'(rsp_data), 32'h4000);
    chk("t1_idle0", 32'(idle), 32'd0);
    step();
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("t1_idle1", 32'(idle), 32'd1);
    chk("t1_hold_d", 32'(rsp_data), 32'h4000);

    // round robin from pointer 0
    do_reset();
    for (int i = 0; i < 4; i++)
      set_op(i, 16'h2000, 16'h4000);
    req_valid = 4'b1111;
    #1;
    chk("rr_g0", 32'(req_ready), 32'h1);
    step();
    chk("rr_g1", 32'(req_ready), 32'h2);
    step();
    chk("rr_g2", 32'(req_ready), 32'h4);
    step();
    chk("rr_g3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_rsp_v", 32'(rsp_valid), 32'(4'b0001 << i));
      chk("rr_rsp_d", 32'(rsp_data), 32'h2000);
    end
    wait_idle("rr_idle");

    // signed op on req1, then skip fairness from pointer 2
    set_op(1, 16'hC000, 16'h4000);
    set_op(3, 16'h1000, 16'h4000);
    set_op(0, 16'h4000, 16'h7FFF);
    req_valid = 4'b0010;
    #1;
    chk("sg_g1", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1001;
    #1;
    chk("fr_g3", 32'(req_ready), 32'h8);
    step();
    chk("fr_g0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    step();
    chk("sg_rsp_v", 32'(rsp_valid), 32'h2);
    chk("sg_rsp_d", 32'(rsp_data), 32'hC000);
    step();
    chk("fr_rsp3_v", 32'(rsp_valid), 32'h8);
    chk("fr_rsp3_d", 32'(rsp_data), 32'h1000);
    step();
    chk("fr_rsp0_v", 32'(rsp_valid), 32'h1);
    chk("fr_rsp0_d", 32'(rsp_data), 32'h7FFF);
    wait_idle("fr_idle");

    // drain: three ops from pointer 1, then disable
    set_op(1, 16'h4000, 16'h0123);
    set_op(2, 16'h4000, 16'h0456);
    set_op(0, 16'h4000, 16'h0789);
    req_valid = 4'b0111;
    #1;
    chk("dr_g1", 32'(req_ready), 32'h2);
    step();
    chk("dr_g2", 32'(req_ready), 32'h4);
    step();
    chk("dr_g0", 32'(req_ready), 32'h1);
    step();
    arb_en = 1'b0;
    #1;
    chk("dr_rdy_off", 32'(req_ready), 32'h0);
    step();
    chk("dr_state", 32'(state), 32'd2);
    arb_en = 1'b1;
    #1;
    chk("dr_ign_en", 32'(req_ready), 32'h0);
    arb_en = 1'b0;
    step();
    chk("dr_rsp1_v", 32'(rsp_valid), 32'h2);
    chk("dr_rsp1_d", 32'(rsp_data), 32'h0123);
    step();
    chk("dr_rsp2_v", 32'(rsp_valid), 32'h4);
    chk("dr_rsp2_d", 32'(rsp_data), 32'h0456);
    step();
    chk("dr_rsp0_v", 32'(rsp_valid), 32'h1);
    chk("dr_rsp0_d", 32'(rsp_data), 32'h0789);
    chk("dr_mul_b", 32'(mul_b), 32'h0789);
    chk("dr_state2", 32'(state), 32'd2);
    chk("dr_idle0", 32'(idle), 32'd0);
    step();
    chk("dr_state0", 32'(state), 32'd0);
    chk("dr_idle1", 32'(idle), 32'd1);
    req_valid = '0;
    arb_en = 1'b1;
    step();

    // reset with two ops in flight
    req_valid = 4'b0011;
    #1;
    chk("rm_g1", 32'(req_ready), 32'h2);
    step();
    chk("rm_g0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    chk("rm_mul_a", 32'(mul_a), 32'h0);
    chk("rm_mul_b", 32'(mul_b), 32'h0);
    chk("rm_ce", 32'(mul_ce), 32'd0);
    chk("rm_rsp_d", 32'(rsp_data), 32'h0);
    chk("rm_state", 32'(state), 32'd0);
    chk("rm_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    seen = rsp_valid;
    repeat (10) begin
      step();
      seen = seen | rsp_valid;
    end
    chk("rm_no_rsp", 32'(seen), 32'h0);
    req_valid = 4'b0011;
    #1;
    chk("rm_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
